alu_share_ctrl: RTL and testbench

- Sequencer/arbiter that time-shares one combinational 4-bit ALU (3-bit opcode, 4-bit result, carry) between two requesters.
- Accepts one operation at a time through a valid/ready handshake and arbitrates round-robin.
- Drives registered opcode/operands to the ALU, waits a fixed settle time, captures the result, and returns it on a response channel tagged with the requester id.
- Sits between client blocks and the shared ALU instance.

---
 rtl/alu_share_ctrl.sv | 138 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that time-shares one combinational ALU between two requesters.
// The operands are registered toward the ALU and the result is captured after ALU_LAT cycles.
module alu_share_ctrl #(
    parameter int W       = 4,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_c,
    output logic           rsp_carry,
    output logic [OPW-1:0] alu_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic [W-1:0]   alu_c,
    input  logic           alu_carry,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam int            CW       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(ALU_LAT - 1);

    state_t         state_q, state_d;
    logic           rr_q, rr_d;
    logic           id_q, id_d;
    logic [CW-1:0]  lat_q, lat_d;
    logic [OPW-1:0] op_q, op_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic           rv_q, rv_d;
    logic           rid_q, rid_d;
    logic [W-1:0]   rc_q, rc_d;
    logic           rcy_q, rcy_d;
    logic           grant0, grant1;

    // rr_q holds the last served id; on a tie the other requester wins.
    assign grant0 = req0_valid & (~req1_valid | rr_q);
    assign grant1 = req1_valid & (~req0_valid | ~rr_q);

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        lat_d      = lat_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rv_d       = rv_q;
        rid_d      = rid_q;
        rc_d       = rc_q;
        rcy_d      = rcy_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 | grant1) begin
                    op_d    = grant1 ? req1_op : req0_op;
                    a_d     = grant1 ? req1_a  : req0_a;
                    b_d     = grant1 ? req1_b  : req0_b;
                    id_d    = grant1;
                    rr_d    = grant1;
                    lat_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                lat_d = lat_q + CW'(1);
                if (lat_q == LAT_LAST) begin
                    rc_d    = alu_c;
                    // Carry is only meaningful for add (0) and sub (1).
                    rcy_d   = (op_q < OPW'(2)) ? alu_carry : 1'b0;
                    rid_d   = id_q;
                    rv_d    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b1;
            id_q    <= 1'b0;
            lat_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rv_q    <= 1'b0;
            rid_q   <= 1'b0;
            rc_q    <= '0;
            rcy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            lat_q   <= lat_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rv_q    <= rv_d;
            rid_q   <= rid_d;
            rc_q    <= rc_d;
            rcy_q   <= rcy_d;
        end
    end

    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign rsp_valid = rv_q;
    assign rsp_id    = rid_q;
    assign rsp_c     = rc_q;
    assign rsp_carry = rcy_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: one instance with ALU_LAT=1 on a behavioural ALU,
// one with ALU_LAT=3 whose ALU result is driven by hand.
module tb_alu_share_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic       r0v, r0r, r1v, r1r;
    logic [2:0] r0op, r1op;
    logic [3:0] r0a, r0b, r1a, r1b;
    logic       rspv, rspr, rspid, rspcy;
    logic [3:0] rspc;
    logic [2:0] aop;
    logic [3:0] aa, ab, ac;
    logic       acy, busy1, force_cy;

    logic       v3, r3, u3_r1r, rspv3, rspid3, rspcy3, busy3;
    logic [2:0] op3, aop3;
    logic [3:0] a3, b3, rspc3, aa3, ab3, ac3;
    logic       acy3;

    alu_share_ctrl #(.W(4), .OPW(3), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(r0r), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(r1r), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b),
        .rsp_valid(rspv), .rsp_ready(rspr), .rsp_id(rspid), .rsp_c(rspc), .rsp_carry(rspcy),
        .alu_op(aop), .alu_a(aa), .alu_b(ab), .alu_c(ac), .alu_carry(acy), .busy(busy1)
    );

    alu_share_ctrl #(.W(4), .OPW(3), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v3), .req0_ready(r3), .req0_op(op3), .req0_a(a3), .req0_b(b3),
        .req1_valid(1'b0), .req1_ready(u3_r1r), .req1_op(3'd0), .req1_a(4'd0), .req1_b(4'd0),
        .rsp_valid(rspv3), .rsp_ready(1'b1), .rsp_id(rspid3), .rsp_c(rspc3), .rsp_carry(rspcy3),
        .alu_op(aop3), .alu_a(aa3), .alu_b(ab3), .alu_c(ac3), .alu_carry(acy3), .busy(busy3)
    );

    // Behavioural shared ALU; force_cy lets the bench raise carry on any opcode.
    logic [4:0] t;
    always_comb begin
        t = 5'd0;
        case (aop)
            3'd0: t = {1'b0, aa} + {1'b0, ab};
            3'd1: t = {1'b0, aa} - {1'b0, ab};
            3'd2: t = {1'b0, aa & ab};
            3'd3: t = {1'b0, aa | ab};
            3'd4: t = {1'b0, ~aa};
            3'd5: t = {1'b0, aa ^ ab};
            3'd6: t = {1'b0, ~(aa & ab)};
            default: t = {1'b0, ~(aa | ab)};
        endcase
        ac  = t[3:0];
        acy = t[4] | force_cy;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        r0v = 0; r0op = 0; r0a = 0; r0b = 0;
        r1v = 0; r1op = 0; r1a = 0; r1b = 0;
        rspr = 1; force_cy = 0;
        v3 = 0; op3 = 0; a3 = 0; b3 = 0; ac3 = 0; acy3 = 0;
        step(); step();
        chk("rst_rspv", rspv, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_alu", {aop, aa}, 0);
        rst_n = 1;
        step();
        chk("rst_rdy", {r0r, r1r}, 0);
        chk("rst_rsp", {rspid, rspcy, rspc}, 0);

        // Single add 8+4, exact latency.
        r0v = 1; r0op = 0; r0a = 8; r0b = 4;
        #1 chk("s_rdy0", r0r, 1);
        step(); r0v = 0;
        chk("s_rdy_drop", r0r, 0);
        chk("s_busy_exec", busy1, 1);
        chk("s_no_rsp_yet", rspv, 0);
        chk("s_alu", {1'b0, aop, aa}, {1'b0, 3'd0, 4'd8});
        chk("s_alub", ab, 4);
        step();
        chk("s_rspv", rspv, 1);
        chk("s_rspc", rspc, 4'hC);
        chk("s_rsp_cy_id", {rspcy, rspid}, 0);
        chk("s_busy_resp", busy1, 1);
        step();
        chk("s_busy_done", busy1, 0);
        chk("s_rspv_done", rspv, 0);

        // Tie arbitration after reset.
        rst_n = 0; step(); rst_n = 1; step();
        r0v = 1; r0op = 2; r0a = 8; r0b = 4;
        r1v = 1; r1op = 3; r1a = 8; r1b = 4;
        #1 chk("tie1_grant", {r0r, r1r}, 2'b10);
        step(); r0v = 0;
        step();
        chk("tie1_rspc", rspc, 0);
        chk("tie1_id", rspid, 0);
        step();
        #1 chk("tie2_grant", {r0r, r1r}, 2'b01);
        step(); r1v = 0;
        step();
        chk("tie2_rspc", rspc, 4'hC);
        chk("tie2_id", rspid, 1);
        r0v = 1; r1v = 1;
        step();
        #1 chk("tie3_grant", {r0r, r1r}, 2'b10);
        step(); r0v = 0;
        step();
        chk("tie3_id", {rspv, rspid}, 2'b10);
        step();
        #1 chk("tie3_then_r1", r1r, 1);
        step(); r1v = 0;
        step(); step();

        // Carry masking.
        force_cy = 1;
        r0v = 1; r0op = 5; r0a = 4'hF; r0b = 4'h1;
        step(); r0v = 0;
        step();
        chk("xor_c", rspc, 4'hE);
        chk("xor_cy_masked", rspcy, 0);
        step(); force_cy = 0;
        r0v = 1; r0op = 0; r0a = 4'hF; r0b = 4'h1;
        step(); r0v = 0;
        step();
        chk("add_c", rspc, 0);
        chk("add_cy", rspcy, 1);
        step();
        r0v = 1; r0op = 1; r0a = 4'h3; r0b = 4'h5;
        step(); r0v = 0;
        step();
        chk("sub_c_borrow", {rspcy, rspc}, 5'h1E);
        step();

        // Backpressure with a pending req1.
        rspr = 0;
        r0v = 1; r0op = 7; r0a = 5; r0b = 3;
        step(); r0v = 0;
        r1v = 1; r1op = 6; r1a = 4'hC; r1b = 4'hA;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp", {rspv, rspid, rspcy, rspc}, {1'b1, 1'b0, 1'b0, 4'h8});
            chk("bp_rdy", {r0r, r1r}, 0);
            chk("bp_alu", {1'b0, aop, aa}, {1'b0, 3'd7, 4'd5});
            chk("bp_alub", ab, 3);
            if (i == 4) rspr = 1;
            step();
        end
        chk("bp_rel_rspv", rspv, 0);
        #1 chk("bp_rel_r1", r1r, 1);
        step(); r1v = 0;
        chk("bp_r1_alu", {1'b0, aop, aa}, {1'b0, 3'd6, 4'hC});
        step();
        chk("bp_r1_rsp", {rspv, rspid, rspc}, {1'b1, 1'b1, 4'h7});
        step();

        // ALU_LAT=3 with a late-changing ALU result.
        v3 = 1; op3 = 0; a3 = 2; b3 = 3; ac3 = 4'hF; acy3 = 1;
        #1 chk("l3_rdy", r3, 1);
        step(); v3 = 0;
        chk("l3_alu_t1", {1'b0, aop3, aa3, ab3}, {1'b0, 3'd0, 4'd2, 4'd3});
        chk("l3_busy", {busy3, rspv3}, 2'b10);
        step();
        chk("l3_alu_t2", {1'b0, aop3, aa3, ab3}, {1'b0, 3'd0, 4'd2, 4'd3});
        chk("l3_norsp_t2", rspv3, 0);
        ac3 = 4'h5; acy3 = 0;
        step();
        chk("l3_alu_t3", {1'b0, aop3, aa3, ab3}, {1'b0, 3'd0, 4'd2, 4'd3});
        chk("l3_norsp_t3", rspv3, 0);
        step();
        chk("l3_rsp", {rspv3, rspid3, rspcy3, rspc3}, {1'b1, 1'b0, 1'b0, 4'h5});
        step();
        chk("l3_idle", {busy3, rspv3, u3_r1r}, 0);

        // Asynchronous reset in EXEC after req0 moved the pointer.
        r0v = 1; r0op = 3; r0a = 1; r0b = 2;
        step(); r0v = 0;
        chk("ra_exec", {busy1, aop, aa}, {1'b1, 3'd3, 4'd1});
        #2 rst_n = 0;
        #1 chk("ra_busy_rspv", {busy1, rspv}, 0);
        chk("ra_alu", {1'b0, aop, aa}, 0);
        chk("ra_alub", ab, 0);
        step(); rst_n = 1;
        r0v = 1; r0op = 2; r0a = 4'hF; r0b = 4'h6;
        r1v = 1; r1op = 3; r1a = 0; r1b = 0;
        #1 chk("ra_tie", {r0r, r1r}, 2'b10);
        step(); r0v = 0;
        step();
        chk("ra_rsp", {rspv, rspid, rspc}, {1'b1, 1'b0, 4'h6});
        r1v = 0;
        step(); step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
